// File: rtl/param_ring_counter_pkg.sv
// param_ring_counter_pkg: mode encoding and seed helper shared by the ring/Johnson counter.
package param_ring_counter_pkg;
  typedef enum logic {RC_RING = 1'b0, RC_JOHNSON = 1'b1} rc_mode_e;
  localparam int RC_MAX_W = 64;
  function automatic logic [RC_MAX_W-1:0] rc_seed(input rc_mode_e mode, input int width, input int init_pos);
    logic [RC_MAX_W-1:0] mask;
    mask = (width >= RC_MAX_W) ? '1 : ((RC_MAX_W'(1) << width) - RC_MAX_W'(1));
    return (mode == RC_JOHNSON) ? '0 : ((RC_MAX_W'(1) << init_pos) & mask);
  endfunction
endpackage

// File: rtl/param_ring_counter_legal.sv
// rc_legal_check: flags codes that are neither one-hot (ring) nor a single-run Johnson code.
module rc_legal_check
  import param_ring_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] cnt,
  input  rc_mode_e         mode,
  output logic             illegal
);
  always_comb
    illegal = (mode == RC_JOHNSON) ? ($countones(cnt[WIDTH-2:0] ^ cnt[WIDTH-1:1]) > 1)
                                   : ($countones(cnt) != 1);
endmodule

// File: rtl/param_ring_counter.sv
// param_ring_counter: ring/Johnson counter with load, wrap pulse and illegal flag.
// PARAM_RING_COUNTER_SELF_CORRECT_EN: a count step on an illegal code reloads the seed.
module param_ring_counter
  import param_ring_counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int INIT_POS = 0
) (
  input  logic             clk,
  input  logic             ori,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt,
  output logic             wrap,
  output logic             illegal
);
  rc_mode_e         mode_in, mode_q;
  logic [WIDTH-1:0] cnt_q, cnt_d, seed_in, seed_q, step, nxt;
  logic             wrap_q, wrap_d, jq, nxt_wrap;
  assign mode_in = rc_mode_e'(mode);
  assign seed_in = WIDTH'(rc_seed(mode_in, WIDTH, INIT_POS));
  assign seed_q  = WIDTH'(rc_seed(mode_q, WIDTH, INIT_POS));
  assign jq      = (mode_q == RC_JOHNSON);
  // Johnson differs from ring only by inverting the bit that wraps around
  assign step = dir ? {cnt_q[WIDTH-2:0], cnt_q[WIDTH-1] ^ jq}
                    : {cnt_q[0] ^ jq, cnt_q[WIDTH-1:1]};
  rc_legal_check #(.WIDTH(WIDTH)) u_legal (
    .cnt     (cnt_q),
    .mode    (mode_q),
    .illegal (illegal)
  );
  always_comb begin
`ifdef PARAM_RING_COUNTER_SELF_CORRECT_EN
    nxt      = illegal ? seed_q : step;
    nxt_wrap = !illegal && (step == seed_q);
`else
    nxt      = step;
    nxt_wrap = (step == seed_q);
`endif
    cnt_d  = load ? load_val : (mode_in != mode_q) ? seed_in : en ? nxt : cnt_q;
    wrap_d = !load && (mode_in == mode_q) && en && nxt_wrap;
  end
  always_ff @(posedge clk) begin
    if (ori) begin
      cnt_q  <= seed_in;
      mode_q <= mode_in;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      mode_q <= mode_in;
      wrap_q <= wrap_d;
    end
  end
  assign cnt  = cnt_q;
  assign wrap = wrap_q;
endmodule

// File: tb/tb_param_ring_counter.sv
// tb_param_ring_counter: scoreboard bench with a reference model plus a width sweep.
module tb_param_ring_counter;
  import param_ring_counter_pkg::*;
  localparam int W = 4;
  localparam int INIT = 0;
`ifdef PARAM_RING_COUNTER_SELF_CORRECT_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic ori = 1'b0, en = 1'b0, mode = 1'b0, dir = 1'b1, load = 1'b0;
  logic [W-1:0] load_val = '0, cnt;
  logic wrap, illegal;
  param_ring_counter #(.WIDTH(W), .INIT_POS(INIT)) dut (
    .clk(clk), .ori(ori), .en(en), .mode(mode), .dir(dir), .load(load),
    .load_val(load_val), .cnt(cnt), .wrap(wrap), .illegal(illegal)
  );
  typedef struct {logic [W-1:0] c; logic w; logic il; string n;} exp_t;
  exp_t sb[$];
  int errors = 0, checks = 0;
  logic [W-1:0] m_c = '0;
  logic m_mq = 1'b0;
  logic lc_ill;
  rc_legal_check #(.WIDTH(W)) u_lc (.cnt(m_c), .mode(rc_mode_e'(m_mq)), .illegal(lc_ill));
  task automatic chk(input string nm, input logic [31:0] g, input logic [31:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, g, e);
    end
  endtask
  function automatic logic [W-1:0] m_seed(input logic md);
    return md ? '0 : (W'(1) << INIT);
  endfunction
  function automatic logic m_ill(input logic [W-1:0] c, input logic md);
    int n = 0;
    if (md) begin
      for (int i = 0; i < W-1; i++) n += (c[i] != c[i+1]) ? 1 : 0;
      return n > 1;
    end
    for (int i = 0; i < W; i++) n += c[i] ? 1 : 0;
    return n != 1;
  endfunction
  task automatic cyc(input logic o, input logic l, input logic [W-1:0] lv,
                     input logic md, input logic e, input logic d, input string nm);
    exp_t x;
    logic wr;
    @(negedge clk);
    ori = o; load = l; load_val = lv; mode = md; en = e; dir = d;
    wr = 1'b0;
    if (o || l || md != m_mq) begin
      m_c = (l && !o) ? lv : m_seed(md);
      m_mq = md;
    end else if (e) begin
      if (SC && m_ill(m_c, m_mq)) m_c = m_seed(m_mq);
      else begin
        m_c = d ? ((m_c << 1) | {{(W-1){1'b0}}, m_c[W-1] ^ m_mq})
                : ((m_c >> 1) | {m_c[0] ^ m_mq, {(W-1){1'b0}}});
        wr = (m_c == m_seed(m_mq));
      end
    end
    x.c = m_c; x.w = wr; x.il = m_ill(m_c, m_mq); x.n = nm;
    sb.push_back(x);
  endtask
  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      exp_t x;
      x = sb.pop_front();
      chk({x.n, " cnt"}, 32'(cnt), 32'(x.c));
      chk({x.n, " wrap"}, 32'(wrap), 32'(x.w));
      chk({x.n, " illegal"}, 32'(illegal), 32'(x.il));
      chk({x.n, " legal_check"}, 32'(lc_ill), 32'(x.il));
    end
  end
  localparam int SW[3] = '{2, 7, 16};
  logic s_ori = 1'b0, s_mode = 1'b0;
  logic [15:0] sw_c[3];
  logic sw_w[3], sw_i[3];
  for (genvar g = 0; g < 3; g++) begin : g_sw
    localparam int SWW = SW[g];
    logic [SWW-1:0] c;
    param_ring_counter #(.WIDTH(SWW), .INIT_POS(SWW-1)) u (
      .clk(clk), .ori(s_ori), .en(1'b1), .mode(s_mode), .dir(1'b1), .load(1'b0),
      .load_val('0), .cnt(c), .wrap(sw_w[g]), .illegal(sw_i[g])
    );
    assign sw_c[g] = 16'(c);
  end
  function automatic logic [15:0] sw_exp(input int w, input int m, input int k);
    int kk;
    logic [31:0] v;
    if (m == 0) begin
      kk = k % w;
      v = 32'(1) << ((w - 1 + kk) % w);
    end else begin
      kk = k % (2 * w);
      v = (kk <= w) ? ((32'(1) << kk) - 1)
                    : (((32'(1) << w) - 1) ^ ((32'(1) << (kk - w)) - 1));
    end
    return v[15:0];
  endfunction
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  initial begin
    logic rmode;
    cyc(1, 0, 0, 0, 1, 1, "rst_ring");
    repeat (4) cyc(0, 0, 0, 0, 1, 1, "ring_up");
    cyc(1, 0, 0, 1, 1, 1, "rst_john");
    repeat (10) cyc(0, 0, 0, 1, 1, 1, "john_up");
    repeat (3) cyc(0, 0, 0, 1, 1, 0, "john_dn");
    cyc(1, 0, 0, 0, 1, 1, "rst_ring2");
    repeat (2) cyc(0, 0, 0, 0, 1, 1, "ring_up2");
    repeat (3) cyc(0, 0, 0, 0, 0, 1, "hold");
    cyc(0, 0, 0, 1, 1, 1, "mode_sw");
    cyc(0, 0, 0, 1, 1, 1, "after_sw");
    cyc(1, 0, 0, 0, 1, 1, "rst_ring3");
    cyc(0, 1, 4'b0110, 0, 0, 1, "load_ill");
    repeat (2) cyc(0, 0, 0, 0, 1, 1, "ill_step");
    cyc(0, 1, 4'b0100, 0, 1, 1, "load_ok");
    cyc(0, 0, 0, 0, 1, 0, "down_step");
    cyc(0, 0, 0, 0, 1, 1, "mid");
    cyc(1, 1, 4'b1010, 0, 1, 1, "simul");
    rmode = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom % 12 == 0) rmode = !rmode;
      cyc(logic'($urandom % 25 == 0), logic'($urandom % 8 == 0), 4'($urandom), rmode,
          logic'($urandom % 4 != 0), logic'($urandom % 2), "rand");
    end
    repeat (2) @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      @(negedge clk);
      s_mode = m[0];
      s_ori = 1'b1;
      @(posedge clk);
      #1;
      for (int g = 0; g < 3; g++) begin
        chk($sformatf("sweep w%0d m%0d seed", SW[g], m), 32'(sw_c[g]), 32'(sw_exp(SW[g], m, 0)));
        chk($sformatf("sweep w%0d m%0d seed_wrap", SW[g], m), 32'(sw_w[g]), 32'(0));
      end
      @(negedge clk);
      s_ori = 1'b0;
      for (int k = 1; k <= 96; k++) begin
        @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
          int per;
          per = (m == 1) ? 2 * SW[g] : SW[g];
          chk($sformatf("sweep w%0d m%0d k%0d cnt", SW[g], m, k), 32'(sw_c[g]), 32'(sw_exp(SW[g], m, k)));
          chk($sformatf("sweep w%0d m%0d k%0d wrap", SW[g], m, k), 32'(sw_w[g]), 32'(k % per == 0));
          chk($sformatf("sweep w%0d m%0d k%0d illegal", SW[g], m, k), 32'(sw_i[g]), 32'(0));
        end
      end
    end
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
